fe_mul: RTL and testbench
=========================

// Module: fe_mul
// PURPOSE
// - Multi-cycle multiplier over the field GF(p), p = 2^255 - 19; computes out = (a * b) mod p.
// - The result is canonical: 0 <= out < p.
// - Sequential datapath: 15 limbs of 17 bits each. b is consumed one limb per cycle, then carries are propagated limb-serially.
// - Arithmetic core of the curve25519 scalar-mult/point-arithmetic engine; driven by a start/done handshake from the sequencer.
// PARAMETERS
// - None. Widths are fixed: field element 255 b, limb 17 b, 15 limbs.
// PORTS
// clock    in   1    single clock; all state changes on rising edge
// reset_n  in   1    synchronous, active-low reset
// start    in   1    1-cycle request; a/b sampled on the same edge
// a        in   255  operand A; any value 0..2^255-1 accepted (non-canonical allowed)
// b        in   255  operand B; same range as a
// done     out  1    high = out valid; held until next accepted start
// out      out  255  canonical product (a*b) mod p; registered
// BEHAVIOUR
// - Clock/reset: one clock. Reset is synchronous and active-low.
//   - reset_n=0 at an edge: state=IDLE, done=0, out=0, multiply_step=0, reduce_step=0, carry=0, all mid[i]=0.
//   - Reset mid-operation aborts the operation; no done is produced.
//   - Reset wins over a simultaneous start.
// - States: IDLE -> MUL -> RED -> FIN -> IDLE.
// - Accepting start: start=1 in IDLE (done may be 0 or 1) at edge E0:
//   - latch a, b into internal regs; clear mid[0..14] and carry; clear done; go to MUL with multiply_step=0.
//   - start while in MUL/RED/FIN is ignored. a and b may change freely after E0.
// - MUL: edges E1..E15, multiply_step j = 0..14.
//   - Each edge, for every limb i: mid[(i+j) mod 15] += a_i * b_j * (i+j >= 15 ? 19 : 1).
//   - The 19 factor uses 2^255 == 19 mod p.
//   - mid[i] accumulators are >= 44 bits wide; they must never overflow for all-ones inputs.
// - RED: edges E16..E45, reduce_step k = 0..29; two serial passes over limbs 0..14 (limb = k mod 15).
//   - Each edge: t = mid[limb] + carry; mid[limb] = t[16:0]; carry = t >> 17.
//   - After limb 14: carry is multiplied by 19 and injected into limb 0 on the next step.
//   - After pass 2, value = sum of mid[i]*2^(17i) < 2^255 and is congruent to a*b mod p.
//     Any final leftover carry*19 is added during FIN.
// - FIN: edge E46.
//   - v = packed limbs (+ leftover carry*19).
//   - out = (v >= p) ? v - p : v, applied until canonical (at most 2 subtractions).
//   - done = 1; go to IDLE.
// - Latency: done rises at exactly the 46th rising edge after the start edge. Throughput: one op per 47 cycles.
// - out and done are stable from E46 until the next accepted start or reset.
//   - done falls on the start edge; out keeps its old value until the next FIN.
// - Back-to-back: start asserted in the same cycle done is high is accepted.
// - Internal signals multiply_step, reduce_step, carry and mid[0..14] are named exactly so for bench probing.
// TESTING
// - Reset: hold reset_n=0 for 2 edges -> done=0, out=0. Then start with a=3, b=5 -> done after 46 edges, out=15.
// - Wrap reduction: a=2^254, b=2 -> out=19. a=2^255-1, b=1 -> out=18 (non-canonical input).
// - Boundary: a=p-1, b=p-1 -> out=1. a=0, b=p-1 -> out=0. a=1, b=p-1 -> out=p-1.
// - Random: a=25728561913544074806655338655832537372072648408242416352266576543536686506277,
//   b=17566812258234732776846655780981983198843065998106887116944655754324067075440
//   -> out == (a*b) mod p per the bigint model; plus 1000 random pairs checked the same way.
// - Handshake: pulse start again mid-MUL -> ignored, latency unchanged.
//   Change a/b after the start edge -> result uses the latched values.
//   Start while done=1 -> done drops next edge.
// - Reset at edge E20 of an operation -> done stays 0 and out=0. A following start completes normally in 46 edges.

Source files
------------

// File: rtl/fe_mul.sv
// fe_mul: multi-cycle multiplier over GF(p), p = 2^255 - 19.
// Computes out = (a * b) mod p, canonical (0 <= out < p).
// Datapath is 15 limbs x 17 bits. One limb of b is consumed per cycle (MUL).
// Carries are then propagated limb-serially in two passes (RED).
// A final conditional subtraction of p happens in FIN.
// Ports:
//   clock    - single clock, rising-edge
//   reset_n  - synchronous active-low reset
//   start    - 1-cycle request; a/b sampled on the same edge (IDLE only)
//   a, b     - 255-bit operands, any value 0..2^255-1
//   done     - result valid; held until the next accepted start
//   out      - registered canonical product
module fe_mul (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         start,
    input  logic [254:0] a,
    input  logic [254:0] b,
    output logic         done,
    output logic [254:0] out
);

    localparam int unsigned NL = 15;
    localparam int unsigned LW = 17;
    localparam int unsigned MW = 48;
    localparam logic [256:0] P_MOD =
        257'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFED;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_RED, S_FIN} state_t;

    state_t          state_q;
    logic [254:0]    a_q;
    logic [254:0]    b_q;
    logic [3:0]      multiply_step;
    logic [4:0]      reduce_step;
    logic [MW-1:0]   carry;
    logic [MW-1:0]   mid [NL];

    logic [MW-1:0]   mid_d [NL];
    logic [LW-1:0]   bj;
    logic [MW-1:0]   prod;
    int unsigned     idx;
    logic [3:0]      red_limb;
    logic [MW-1:0]   red_t;
    logic [MW-1:0]   carry_d;
    logic [254:0]    packed_v;
    logic [256:0]    fin_v;

    // Multiply step: add a * b_j into the accumulators, folding the
    // columns that wrap past limb 14 back with weight 19 (2^255 == 19 mod p).
    always_comb begin
        bj   = b_q[LW*multiply_step +: LW];
        prod = '0;
        idx  = 0;
        for (int unsigned i = 0; i < NL; i++) begin
            mid_d[i] = mid[i];
        end
        for (int unsigned i = 0; i < NL; i++) begin
            idx  = i + 32'(multiply_step);
            prod = MW'(a_q[LW*i +: LW]) * MW'(bj);
            if (idx >= NL) begin
                idx  = idx - NL;
                prod = prod * MW'(19);
            end
            mid_d[idx] = mid[idx] + prod;
        end
    end

    // Reduction step: one limb per cycle; the carry out of limb 14 is
    // pre-multiplied by 19 so it can be added straight into limb 0.
    always_comb begin
        red_limb = (reduce_step < 5'd15) ? reduce_step[3:0] : 4'(reduce_step - 5'd15);
        red_t    = mid[red_limb] + carry;
        carry_d  = red_t >> LW;
        if (red_limb == 4'd14) begin
            carry_d = carry_d * MW'(19);
        end
    end

    // Final: pack limbs, add leftover carry, subtract p up to twice.
    always_comb begin
        packed_v = '0;
        for (int unsigned i = 0; i < NL; i++) begin
            packed_v[LW*i +: LW] = mid[i][LW-1:0];
        end
        fin_v = {2'b00, packed_v} + 257'(carry);
        if (fin_v >= P_MOD) fin_v = fin_v - P_MOD;
        if (fin_v >= P_MOD) fin_v = fin_v - P_MOD;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            done          <= 1'b0;
            out           <= '0;
            a_q           <= '0;
            b_q           <= '0;
            multiply_step <= '0;
            reduce_step   <= '0;
            carry         <= '0;
            for (int unsigned i = 0; i < NL; i++) mid[i] <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q           <= a;
                        b_q           <= b;
                        done          <= 1'b0;
                        carry         <= '0;
                        multiply_step <= '0;
                        for (int unsigned i = 0; i < NL; i++) mid[i] <= '0;
                        state_q       <= S_MUL;
                    end
                end
                S_MUL: begin
                    for (int unsigned i = 0; i < NL; i++) mid[i] <= mid_d[i];
                    if (multiply_step == 4'd14) begin
                        multiply_step <= '0;
                        reduce_step   <= '0;
                        state_q       <= S_RED;
                    end else begin
                        multiply_step <= multiply_step + 4'd1;
                    end
                end
                S_RED: begin
                    mid[red_limb] <= {{(MW-LW){1'b0}}, red_t[LW-1:0]};
                    carry         <= carry_d;
                    if (reduce_step == 5'd29) begin
                        reduce_step <= '0;
                        state_q     <= S_FIN;
                    end else begin
                        reduce_step <= reduce_step + 5'd1;
                    end
                end
                S_FIN: begin
                    out     <= fin_v[254:0];
                    done    <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fe_mul.sv
// tb_fe_mul: directed and random checks of fe_mul against a
// shift-and-add modular multiplication model.
module tb_fe_mul;

    localparam logic [256:0] P_MOD =
        257'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFED;

    logic         clock;
    logic         reset_n;
    logic         start;
    logic [254:0] a;
    logic [254:0] b;
    logic         done;
    logic [254:0] out;

    int checks;
    int failures;

    fe_mul dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .done    (done),
        .out     (out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [256:0] got, input logic [256:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [256:0] modmul(input logic [254:0] x, input logic [254:0] y);
        logic [256:0] r;
        logic [256:0] ym;
        r  = '0;
        ym = {2'b00, y};
        if (ym >= P_MOD) ym = ym - P_MOD;
        for (int i = 254; i >= 0; i--) begin
            r = r << 1;
            if (r >= P_MOD) r = r - P_MOD;
            if (x[i]) begin
                r = r + ym;
                if (r >= P_MOD) r = r - P_MOD;
            end
        end
        return r;
    endfunction

    function automatic logic [254:0] rand255();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v[254:0];
    endfunction

    // One full operation; optionally scrambles a/b after the start edge
    // and pulses start again mid-MUL. Checks done drop, latency and result.
    task automatic run_op(input string tag, input logic [254:0] av, input logic [254:0] bv,
                          input logic [256:0] exp, input bit scramble, input bit pulse_mid);
        int lat;
        @(negedge clock);
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        if (scramble) begin
            a = ~av;
            b = av ^ bv;
        end
        check({tag, "_done_drop"}, {256'b0, done}, 257'd0);
        lat = 0;
        while (!done && lat < 60) begin
            @(posedge clock);
            #1;
            lat++;
            start = pulse_mid && (lat == 5);
        end
        start = 1'b0;
        check({tag, "_latency"}, 257'(lat), 257'd46);
        check({tag, "_out"}, {2'b00, out}, exp);
    endtask

    logic [254:0] ra;
    logic [254:0] rb;

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_done", {256'b0, done}, 257'd0);
        check("rst_out", {2'b00, out}, 257'd0);
        check("rst_carry", 257'(dut.carry), 257'd0);
        check("rst_mstep", 257'(dut.multiply_step), 257'd0);
        check("rst_mid7", 257'(dut.mid[7]), 257'd0);
        @(negedge clock);
        reset_n = 1'b1;

        run_op("3x5", 255'd3, 255'd5, 257'd15, 1'b0, 1'b0);
        run_op("wrap2", 255'd1 << 254, 255'd2, 257'd19, 1'b0, 1'b0);
        run_op("allones", '1, 255'd1, 257'd18, 1'b0, 1'b0);
        run_op("pm1sq", P_MOD[254:0] - 255'd1, P_MOD[254:0] - 255'd1, 257'd1, 1'b0, 1'b0);
        run_op("zero", 255'd0, P_MOD[254:0] - 255'd1, 257'd0, 1'b0, 1'b0);
        run_op("one", 255'd1, P_MOD[254:0] - 255'd1, P_MOD - 257'd1, 1'b0, 1'b0);
        run_op("ones_sq", '1, '1, 257'd324, 1'b0, 1'b0);

        ra = 255'd25728561913544074806655338655832537372072648408242416352266576543536686506277;
        rb = 255'd17566812258234732776846655780981983198843065998106887116944655754324067075440;
        run_op("fixed_rand", ra, rb, modmul(ra, rb), 1'b0, 1'b0);

        run_op("scramble", 255'd3, 255'd5, 257'd15, 1'b1, 1'b0);
        run_op("pulse_mid", 255'd7, 255'd11, 257'd77, 1'b0, 1'b1);

        // Reset at edge E20 of an operation aborts it.
        @(negedge clock);
        a = 255'd9;
        b = 255'd9;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (19) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        check("abort_out", {2'b00, out}, 257'd0);
        begin
            int seen;
            seen = 0;
            repeat (50) begin
                @(posedge clock);
                #1;
                if (done) seen++;
            end
            check("abort_no_done", 257'(seen), 257'd0);
        end
        check("abort_out_hold", {2'b00, out}, 257'd0);
        run_op("after_abort", 255'd12, 255'd12, 257'd144, 1'b0, 1'b0);

        for (int n = 0; n < 1000; n++) begin
            ra = rand255();
            rb = rand255();
            run_op("rand", ra, rb, modmul(ra, rb), 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
